// File: rtl/ssd_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : ssd_scan_driver
//  Purpose  : Time-multiplexes four hex digits onto one common-anode
//             seven-segment display. Each digit owns a slot of REFRESH_DIV
//             clocks. The first BLANK_CYCLES clocks of every slot keep all
//             anodes off as a ghosting guard. Digit data is snapshotted at
//             the start of its slot, so the displayed digit cannot tear.
//  Options  : SSD_BRIGHTNESS_EN adds brightness_i[2:0], which PWM-gates the
//             lit window in 8-cycle frames. When the macro is undefined the
//             lit window is fully on.
//  Revision : 1.0  initial release
// ============================================================================
module ssd_scan_driver #(
  parameter int REFRESH_DIV  = 1000,  // clocks per digit slot, 2..65535
  parameter int BLANK_CYCLES = 4      // guard clocks per slot, < REFRESH_DIV
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       digit0_en_i,
  input  logic       digit1_en_i,
  input  logic       digit2_en_i,
  input  logic       digit3_en_i,
  input  logic [3:0] digit0_i,
  input  logic [3:0] digit1_i,
  input  logic [3:0] digit2_i,
  input  logic [3:0] digit3_i,
  input  logic [3:0] dp_i,
`ifdef SSD_BRIGHTNESS_EN
  input  logic [2:0] brightness_i,
`endif
  output logic [3:0] anodes_o,
  output logic [6:0] segments_o,
  output logic       dp_o
);

  localparam logic [15:0] c_last  = 16'(REFRESH_DIV - 1);
  localparam logic [15:0] c_blank = 16'(BLANK_CYCLES);

  // Hex to active-low {g,f,e,d,c,b,a} cathode pattern.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot counter, digit index and per-slot snapshot.
  logic [15:0] p_q, p_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  snap_val_q, snap_val_d;
  logic        snap_en_q, snap_en_d;
  logic        snap_dp_q, snap_dp_d;

  // Registered display outputs.
  logic [3:0]  anodes_q, anodes_d;
  logic [6:0]  segments_q, segments_d;
  logic        dp_q, dp_d;

  // Live digit fields selected by the current index.
  logic [3:0]  w_live_val;
  logic        w_live_en;
  logic        w_live_dp;
  logic        w_slot_start;
  logic        w_wrap;

  // Effective digit data for this cycle (live at slot start, else snapshot).
  logic [3:0]  w_val;
  logic        w_en;
  logic        w_dp;
  logic        w_in_window;
  logic        w_bright_ok;
  logic        w_on;

  assign w_slot_start = (p_q == 16'd0);
  assign w_wrap       = (p_q == c_last);

  // Pick the digit fields belonging to the current slot index.
  always_comb begin
    w_live_val = digit0_i;
    w_live_en  = digit0_en_i;
    w_live_dp  = dp_i[0];
    case (idx_q)
      2'd1: begin
        w_live_val = digit1_i;
        w_live_en  = digit1_en_i;
        w_live_dp  = dp_i[1];
      end
      2'd2: begin
        w_live_val = digit2_i;
        w_live_en  = digit2_en_i;
        w_live_dp  = dp_i[2];
      end
      2'd3: begin
        w_live_val = digit3_i;
        w_live_en  = digit3_en_i;
        w_live_dp  = dp_i[3];
      end
      default: begin
        w_live_val = digit0_i;
        w_live_en  = digit0_en_i;
        w_live_dp  = dp_i[0];
      end
    endcase
  end

  // At p==0 the snapshot is being loaded on this very edge, so the live
  // values are used directly; this only matters when BLANK_CYCLES is 0.
  assign w_val       = w_slot_start ? w_live_val : snap_val_q;
  assign w_en        = w_slot_start ? w_live_en  : snap_en_q;
  assign w_dp        = w_slot_start ? w_live_dp  : snap_dp_q;
  assign w_in_window = (p_q >= c_blank);

`ifdef SSD_BRIGHTNESS_EN
  localparam logic [2:0] c_blank_lo = 3'(BLANK_CYCLES);

  logic [2:0] snap_bri_q, snap_bri_d;
  logic [2:0] w_bri;
  logic [2:0] w_phase;

  assign w_bri       = w_slot_start ? brightness_i : snap_bri_q;
  // Only the low three bits matter for (p - BLANK_CYCLES) mod 8.
  assign w_phase     = p_q[2:0] - c_blank_lo;
  assign w_bright_ok = (w_phase <= w_bri);
  assign snap_bri_d  = w_slot_start ? brightness_i : snap_bri_q;

  // Brightness level captured together with the digit snapshot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snap_bri_q <= 3'd0;
    end else begin
      snap_bri_q <= snap_bri_d;
    end
  end
`else
  assign w_bright_ok = 1'b1;
`endif

  assign w_on = w_in_window & w_en & w_bright_ok;

  // Next-state for the scan counters, snapshot and outputs.
  always_comb begin
    p_d        = w_wrap ? 16'd0 : (p_q + 16'd1);
    idx_d      = w_wrap ? (idx_q + 2'd1) : idx_q;
    snap_val_d = w_slot_start ? w_live_val : snap_val_q;
    snap_en_d  = w_slot_start ? w_live_en  : snap_en_q;
    snap_dp_d  = w_slot_start ? w_live_dp  : snap_dp_q;
    anodes_d   = 4'hF;
    segments_d = 7'h7F;
    dp_d       = 1'b1;
    if (w_on) begin
      anodes_d   = ~(4'b0001 << idx_q);
      segments_d = seg_decode(w_val);
      dp_d       = ~w_dp;
    end
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_q        <= 16'd0;
      idx_q      <= 2'd0;
      snap_val_q <= 4'd0;
      snap_en_q  <= 1'b0;
      snap_dp_q  <= 1'b0;
      anodes_q   <= 4'hF;
      segments_q <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      p_q        <= p_d;
      idx_q      <= idx_d;
      snap_val_q <= snap_val_d;
      snap_en_q  <= snap_en_d;
      snap_dp_q  <= snap_dp_d;
      anodes_q   <= anodes_d;
      segments_q <= segments_d;
      dp_q       <= dp_d;
    end
  end

  assign anodes_o   = anodes_q;
  assign segments_o = segments_q;
  assign dp_o       = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ssd_scan_driver
//  Purpose  : Directed self-checking bench for ssd_scan_driver with
//             REFRESH_DIV=8, BLANK_CYCLES=2.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ssd_scan_driver;

  localparam int RD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en0, en1, en2, en3;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] dp;
  logic [3:0] anodes;
  logic [6:0] segments;
  logic       dpo;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Expected per-slot pattern while lit (anode F means the slot stays dark).
  logic [3:0] exp_an  [4];
  logic [6:0] exp_seg [4];
  logic       exp_dp  [4];

  logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  ssd_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .digit0_en_i (en0),
    .digit1_en_i (en1),
    .digit2_en_i (en2),
    .digit3_en_i (en3),
    .digit0_i    (d0),
    .digit1_i    (d1),
    .digit2_i    (d2),
    .digit3_i    (d3),
    .dp_i        (dp),
`ifdef SSD_BRIGHTNESS_EN
    .brightness_i(3'd7),
`endif
    .anodes_o    (anodes),
    .segments_o  (segments),
    .dp_o        (dpo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_an",  {28'd0, anodes},   32'hF);
    check("rst_seg", {25'd0, segments}, 32'h7F);
    check("rst_dp",  {31'd0, dpo},      32'h1);
    rst = 1'b0;
    cyc = 0;
  endtask

  // Output after edge k reflects the counter state p=(k-1)%RD of slot (k-1)/RD.
  task automatic run_cycles(input int n);
    int slot, p;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    for (int i = 0; i < n; i++) begin
      tick();
      cyc++;
      slot = ((cyc - 1) / RD) % 4;
      p    = (cyc - 1) % RD;
      if (p < BC) begin
        ea = 4'hF; es = 7'h7F; ed = 1'b1;
      end else if (exp_an[slot] == 4'hF) begin
        ea = 4'hF; es = 7'h7F; ed = 1'b1;
      end else begin
        ea = exp_an[slot]; es = exp_seg[slot]; ed = exp_dp[slot];
      end
      check($sformatf("an c%0d", cyc),  {28'd0, anodes},   {28'd0, ea});
      check($sformatf("seg c%0d", cyc), {25'd0, segments}, {25'd0, es});
      check($sformatf("dp c%0d", cyc),  {31'd0, dpo},      {31'd0, ed});
      check($sformatf("onehot c%0d", cyc), {31'd0, ($countones(~anodes) <= 1)}, 32'd1);
    end
  endtask

  task automatic set_default_tables();
    exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
    exp_dp  = '{1'b1, 1'b1, 1'b1, 1'b1};
  endtask

  initial begin
    en0 = 1'b1; en1 = 1'b1; en2 = 1'b1; en3 = 1'b1;
    d0 = 4'h1; d1 = 4'hF; d2 = 4'h0; d3 = 4'h8;
    dp = 4'b0000;

    // Basic scan: digits 1,F,0,8, slightly more than one full scan.
    set_default_tables();
    exp_seg = '{7'h79, 7'h0E, 7'h40, 7'h00};
    do_reset();
    run_cycles(40);

    // Disabled digit 2 stays dark; slot 3 keeps its timing.
    en2 = 1'b0;
    set_default_tables();
    exp_an[2] = 4'hF;
    do_reset();
    run_cycles(32);
    en2 = 1'b1;

    // Mid-slot change of digit 0 does not tear the displayed digit.
    d0 = 4'h3;
    set_default_tables();
    exp_seg = '{7'h30, 7'h0E, 7'h40, 7'h00};
    do_reset();
    run_cycles(4);
    d0 = 4'h5;
    run_cycles(28);
    exp_seg[0] = 7'h12;
    run_cycles(8);

    // Reset pulse in the middle of digit 2's slot.
    d0 = 4'h1;
    set_default_tables();
    exp_seg = '{7'h79, 7'h0E, 7'h40, 7'h00};
    do_reset();
    run_cycles(20);
    check("pre_rst_an", {28'd0, anodes}, 32'hB);
    rst = 1'b1;
    #1;
    check("async_an",  {28'd0, anodes},   32'hF);
    check("async_seg", {25'd0, segments}, 32'h7F);
    check("async_dp",  {31'd0, dpo},      32'h1);
    tick();
    rst = 1'b0;
    cyc = 0;
    run_cycles(8);

    // Decimal point on digit 0 only, all digits 0.
    d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
    dp = 4'b0001;
    set_default_tables();
    exp_dp  = '{1'b0, 1'b1, 1'b1, 1'b1};
    exp_seg = '{7'h40, 7'h40, 7'h40, 7'h40};
    do_reset();
    run_cycles(32);
    dp = 4'b0000;

    // Sweep the whole decode table, four values per scan.
    for (int v = 0; v < 16; v += 4) begin
      d0 = 4'(v); d1 = 4'(v + 1); d2 = 4'(v + 2); d3 = 4'(v + 3);
      set_default_tables();
      exp_seg = '{dec_tbl[v], dec_tbl[v + 1], dec_tbl[v + 2], dec_tbl[v + 3]};
      do_reset();
      run_cycles(32);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
